if_fetch_unit: RTL and testbench

Instruction fetch front-end that reads the program counter and drives its update.
- Issues pipelined requests to instruction memory at the current PC and advances the PC by 4 per accepted request.
- Pairs in-order memory responses with their PCs in a small buffer and hands {pc, instruction} to decode over a valid/ready handshake.
- Applies branch/jump redirects by flushing buffered instructions and discarding in-flight responses.

---
 rtl/if_fetch_unit.sv | 101 ++++++++++
 tb/tb_if_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front-end.
// Issues PC requests, pairs in-order responses with PCs, flushes on redirect.
module if_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_enable_o,
  output logic [31:0] next_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [CW-1:0] outstanding;
  logic [CW-1:0] drops;
  logic [CW-1:0] count;
  logic [AW-1:0] pend_wr;
  logic [AW-1:0] pend_rd;
  logic [AW-1:0] buf_wr;
  logic [AW-1:0] buf_rd;
  logic [31:0]   pend_pc [DEPTH];
  logic [31:0]   buf_pc [DEPTH];
  logic [31:0]   buf_inst [DEPTH];
  logic [CW:0]   credit;
  logic          fire;
  logic          resp;
  logic          keep;
  logic          pop;

  always_comb begin
    credit = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid_o = !rst && !redirect_i && (credit < LIMIT);
    fire = imem_req_valid_o && imem_req_ready_i;
    // a response with nothing outstanding is a protocol error: ignore it
    resp = !rst && imem_resp_valid_i && (outstanding != '0);
    keep = resp && !redirect_i && (drops == '0);
    pop = !rst && !redirect_i && inst_ready_i && (count != '0);
    pc_enable_o = !rst && (redirect_i || fire);
    next_pc_o = pc_i;
    if (redirect_i)
      next_pc_o = redirect_pc_i;
    else if (fire)
      next_pc_o = pc_i + 32'd4;
  end

  assign imem_req_addr_o = pc_i;
  assign inst_valid_o = !rst && (count != '0);
  assign inst_o = buf_inst[buf_rd];
  assign inst_pc_o = buf_pc[buf_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drops <= '0;
      count <= '0;
      pend_wr <= '0;
      pend_rd <= '0;
      buf_wr <= '0;
      buf_rd <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(resp);
      if (fire) begin
        pend_pc[pend_wr] <= pc_i;
        pend_wr <= pend_wr + AW'(1);
      end
      if (resp)
        pend_rd <= pend_rd + AW'(1);
      if (redirect_i) begin
        // every response still in flight belongs to the old path
        drops <= outstanding - CW'(resp);
        count <= '0;
        buf_wr <= '0;
        buf_rd <= '0;
      end else begin
        if (resp && (drops != '0))
          drops <= drops - CW'(1);
        if (keep) begin
          buf_pc[buf_wr] <= pend_pc[pend_rd];
          buf_inst[buf_wr] <= imem_resp_data_i;
          buf_wr <= buf_wr + AW'(1);
        end
        if (pop)
          buf_rd <= buf_rd + AW'(1);
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized fetch bench with a PC-stream scoreboard.
// Delivered {pc, inst} must follow the sequential path from the last reset/redirect.
module tb_if_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i;
  logic        pc_enable_o;
  logic [31:0] next_pc_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  if_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .pc_i(pc_i),
    .pc_enable_o(pc_enable_o),
    .next_pc_o(next_pc_o),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i(imem_resp_data_i),
    .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i),
    .inst_o(inst_o),
    .inst_pc_o(inst_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next = '0;
  logic [31:0] pc_reset = '0;
  logic [31:0] last_pc = '0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          nfire = 0;
  int          ndeliv = 0;
  int          mem_delay = 0;
  int          last_due = 0;
  bit          saw_wrap = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endfunction

  // external PC register
  always @(posedge clk) begin
    if (rst)
      pc_i <= pc_reset;
    else if (pc_enable_o)
      pc_i <= next_pc_o;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor, scoreboard and memory request capture
  logic [31:0] m_exp;
  logic [31:0] m_npc;
  bit          m_fire;
  int          m_infl;
  int          m_due;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", imem_req_valid_o, 0);
      chk("rst_pc_enable", pc_enable_o, 0);
      chk("rst_inst_valid", inst_valid_o, 0);
      exp_q.delete();
      exp_next = pc_reset;
    end else begin
      m_fire = imem_req_valid_o && imem_req_ready_i;
      m_infl = resp_q.size() + (imem_resp_valid_i ? 1 : 0);
      m_npc = redirect_i ? redirect_pc_i : (m_fire ? pc_i + 32'd4 : pc_i);
      chk("req_addr", imem_req_addr_o, pc_i);
      chk("pc_enable", pc_enable_o, redirect_i || m_fire);
      chk("next_pc", next_pc_o, m_npc);
      if (redirect_i)
        chk("redirect_no_req", imem_req_valid_o, 0);
      if (m_infl >= DEPTH)
        chk("credit_no_req", imem_req_valid_o, 0);
      if (inst_valid_o && inst_ready_i && !redirect_i) begin
        m_exp = exp_q.pop_front();
        chk("inst_pc", inst_pc_o, m_exp);
        chk("inst_data", inst_o, mem_word(m_exp));
        last_pc = inst_pc_o;
        if (m_exp == 32'h0 && inst_pc_o == 32'h0)
          saw_wrap = 1'b1;
        ndeliv++;
      end
      if (redirect_i) begin
        exp_q.delete();
        exp_next = redirect_pc_i;
      end
      if (m_fire) begin
        m_due = cyc + 1 + mem_delay;
        if (m_due <= last_due)
          m_due = last_due + 1;
        last_due = m_due;
        resp_q.push_back('{due: m_due, data: mem_word(imem_req_addr_o)});
        nfire++;
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  end

  task automatic mem_drive();
    if (rst) begin
      resp_q.delete();
      last_due = cyc;
      imem_resp_valid_i = 1'b0;
    end else if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i = resp_q[0].data;
      resp_q.delete(0);
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i = $urandom;
    end
  endtask

  task automatic cycle(input bit r, input bit rd, input logic [31:0] rpc,
                       input bit qr, input bit ir);
    @(posedge clk);
    #1;
    rst = r;
    redirect_i = rd;
    redirect_pc_i = rpc;
    imem_req_ready_i = qr;
    inst_ready_i = ir;
    mem_drive();
  endtask

  task automatic do_reset(input logic [31:0] start);
    pc_reset = start;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic wait_first(input string n, input logic [31:0] want);
    int n0;
    n0 = ndeliv;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 0, 1, 1);
      if (ndeliv > n0)
        break;
    end
    chk({n, "_delivered"}, ndeliv > n0, 1);
    chk({n, "_first_pc"}, last_pc, want);
  endtask

  initial begin
    int n0;
    int f0;
    logic [31:0] t;
    bit r;
    bit rd;

    // back-to-back fetch from 0
    mem_delay = 0;
    do_reset(32'h0);
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t1_npc0", next_pc_o, 32'h4);
    chk("t1_valid0", inst_valid_o, 0);
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t1_npc1", next_pc_o, 32'h8);
    chk("t1_valid1", inst_valid_o, 0);
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t1_valid2", inst_valid_o, 1);
    chk("t1_pc2", inst_pc_o, 32'h0);
    chk("t1_inst2", inst_o, mem_word(32'h0));
    cycle(0, 0, 0, 1, 1);
    n0 = ndeliv;
    repeat (12) cycle(0, 0, 0, 1, 1);
    chk("t1_throughput_ge8", (ndeliv - n0) >= 8, 1);

    // decode stalled: credit limit, then drain and resume
    do_reset(32'h0);
    f0 = nfire;
    repeat (6) cycle(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("t2_req_blocked", imem_req_valid_o, 0);
    chk("t2_pc_hold", pc_enable_o, 0);
    cycle(0, 0, 0, 1, 1);
    chk("t2_fires", nfire - f0, 2);
    n0 = ndeliv;
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t2_resume_valid", imem_req_valid_o, 1);
    chk("t2_resume_addr", imem_req_addr_o, 32'h8);
    cycle(0, 0, 0, 1, 1);
    chk("t2_drained", ndeliv - n0, 2);

    // redirect with two requests in flight, no response that cycle
    mem_delay = 4;
    do_reset(32'h10);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 32'h100, 1, 1);
    @(negedge clk);
    chk("t3_redirect_en", pc_enable_o, 1);
    chk("t3_redirect_pc", next_pc_o, 32'h100);
    mem_delay = 0;
    wait_first("t3", 32'h100);

    // redirect coincident with a response, one more in flight
    mem_delay = 1;
    do_reset(32'h40);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 32'h200, 1, 1);
    mem_delay = 0;
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t4_empty", inst_valid_o, 0);
    chk("t4_req_valid", imem_req_valid_o, 1);
    chk("t4_req_addr", imem_req_addr_o, 32'h200);
    wait_first("t4", 32'h200);

    // PC wrap
    saw_wrap = 1'b0;
    do_reset(32'hFFFF_FFF8);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t5_wrap_en", pc_enable_o, 1);
    chk("t5_wrap_npc", next_pc_o, 32'h0);
    repeat (6) cycle(0, 0, 0, 1, 1);
    chk("t5_wrap_delivered", saw_wrap, 1);

    // reset mid-stream
    mem_delay = 1;
    do_reset(32'h80);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    pc_reset = 32'h300;
    mem_delay = 0;
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t6_inst_valid", inst_valid_o, 0);
    chk("t6_req_valid", imem_req_valid_o, 1);
    chk("t6_req_addr", imem_req_addr_o, 32'h300);
    wait_first("t6", 32'h300);

    // randomized traffic
    n0 = ndeliv;
    for (int i = 0; i < 3000; i++) begin
      mem_delay = $urandom_range(0, 2);
      r = ($urandom_range(0, 199) == 0);
      rd = !r && ($urandom_range(0, 99) < 5);
      t = $urandom;
      t[1:0] = 2'b00;
      if (r) begin
        pc_reset = $urandom;
        pc_reset[1:0] = 2'b00;
      end
      cycle(r, rd, t, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end
    repeat (4) cycle(0, 0, 0, 1, 1);
    chk("rand_progress_gt300", (ndeliv - n0) > 300, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
